// File: rtl/parity_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : parity_pkg
//  Purpose  : Shared types and constants for the streaming parity generator.
//             Holds the packet-tracking FSM state encoding and the parity
//             mode constants.
//  Revision : 1.0 - initial release
// ============================================================================
package parity_pkg;

    // Packet-tracking FSM states, explicitly encoded in two bits
    typedef enum logic [1:0] {
        IDLE    = 2'd0,  // waiting for the first beat of a packet
        BODY    = 2'd1,  // inside a packet, accumulating column parity
        TRAILER = 2'd2   // last beat accepted, LRC word still to be emitted
    } state_t;

    // Parity mode encoding as seen on odd_even
    localparam logic MODE_EVEN = 1'b0;
    localparam logic MODE_ODD  = 1'b1;

endpackage : parity_pkg
`default_nettype wire

// File: rtl/parity_calc.sv
`default_nettype none
// ============================================================================
//  Module   : parity_calc
//  Purpose  : Combinational parity of a DATA_W-bit word. With mode = 1 the
//             result makes the total count of ones (word + bit) odd, with
//             mode = 0 it makes it even.
//  Revision : 1.0 - initial release
// ============================================================================
module parity_calc #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    input  logic              mode,
    output logic              par
);

    // Reduction XOR folds the word; XOR with mode flips even into odd parity
    assign par = (^data) ^ mode;

endmodule : parity_calc
`default_nettype wire

// File: rtl/parity_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module   : parity_stream_gen
//  Purpose  : Streaming parity generator. Tags every accepted word with a
//             per-word parity bit and appends one longitudinal-parity (LRC)
//             trailer word after the last word of each packet. Parity mode
//             (odd/even) is latched on the first beat of each packet.
//  Revision : 1.0 - initial release
// ============================================================================
module parity_stream_gen
    import parity_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              odd_even,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_par,
    output logic              m_last,
    output logic              m_trailer
);

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_next;

    logic [DATA_W-1:0]   r_acc;
    logic                r_mode;

    logic                r_m_valid;
    logic [DATA_W-1:0]   r_m_data;
    logic                r_m_par;
    logic                r_m_last;
    logic                r_m_trailer;

    logic                w_out_free;   // output register may take a new word
    logic                w_s_ready;
    logic                w_in_xfer;    // input handshake completes this cycle
    logic                w_trl_load;   // trailer word loads this cycle
    logic                w_beat_mode;  // mode that applies to the incoming word
    logic                w_beat_par;
    logic [DATA_W-1:0]   w_lrc;
    logic                w_lrc_par;

    // ------------------------------------------------------------------------
    // Parity calculators
    // ------------------------------------------------------------------------

    // The first beat of a packet has to be tagged with the mode being latched
    // in that same cycle, so bypass the mode register while in IDLE.
    assign w_beat_mode = (r_state == IDLE) ? odd_even : r_mode;

    // Inverting every column in odd mode turns the even column parity held
    // in the accumulator into odd column parity.
    assign w_lrc = r_acc ^ {DATA_W{r_mode}};

    parity_calc #(
        .DATA_W (DATA_W)
    ) u_par_data (
        .data (s_data),
        .mode (w_beat_mode),
        .par  (w_beat_par)
    );

    parity_calc #(
        .DATA_W (DATA_W)
    ) u_par_lrc (
        .data (w_lrc),
        .mode (r_mode),
        .par  (w_lrc_par)
    );

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: a last beat always leads to TRAILER; the trailer
    // leaves as soon as the output register is free to take it.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE, BODY: begin
                if (w_in_xfer) begin
                    w_state_next = s_last ? TRAILER : BODY;
                end
            end
            TRAILER: begin
                if (w_out_free) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // FSM outputs: input readiness and the trailer-load strobe. The output
    // register is free when empty or being drained this cycle.
    always_comb begin
        w_out_free = !r_m_valid || m_ready;
        w_s_ready  = (r_state != TRAILER) && w_out_free;
        w_trl_load = (r_state == TRAILER) && w_out_free;
        w_in_xfer  = s_valid && w_s_ready;
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------

    // Mode latch and column-parity accumulator; cleared once the trailer is
    // loaded so a stale sum never leaks into the next packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= MODE_EVEN;
            r_acc  <= '0;
        end else if (w_in_xfer) begin
            if (r_state == IDLE) begin
                r_mode <= odd_even;
                r_acc  <= s_data;
            end else begin
                r_acc  <= r_acc ^ s_data;
            end
        end else if (w_trl_load) begin
            r_acc  <= '0;
        end
    end

    // Output register: data beats and trailer are mutually exclusive because
    // no input is accepted in TRAILER. A drain without a reload only clears
    // m_valid, leaving the last word visible on the other outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_m_par     <= 1'b0;
            r_m_last    <= 1'b0;
            r_m_trailer <= 1'b0;
        end else if (w_in_xfer) begin
            r_m_valid   <= 1'b1;
            r_m_data    <= s_data;
            r_m_par     <= w_beat_par;
            r_m_last    <= 1'b0;
            r_m_trailer <= 1'b0;
        end else if (w_trl_load) begin
            r_m_valid   <= 1'b1;
            r_m_data    <= w_lrc;
            r_m_par     <= w_lrc_par;
            r_m_last    <= 1'b1;
            r_m_trailer <= 1'b1;
        end else if (r_m_valid && m_ready) begin
            r_m_valid   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Port drives
    // ------------------------------------------------------------------------
    assign s_ready   = w_s_ready;
    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign m_par     = r_m_par;
    assign m_last    = r_m_last;
    assign m_trailer = r_m_trailer;

endmodule : parity_stream_gen
`default_nettype wire
